wb_arb_2m_sdr: RTL and testbench

// Two-master Wishbone B3 arbiter feeding the single slave port of sdr_sdram_16_ctrl.

---
 rtl/wb_arb_2m_sdr.sv | 150 +++++++++++++++
 tb/tb_wb_arb_2m_sdr.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_2m_sdr.sv
// Two-master Wishbone B3 round-robin arbiter in front of the SDRAM controller slave port.
// The grant is held for the whole cyc so bursts reach the slave unbroken; a watchdog ends hung cycles with err.
module wb_arb_2m_sdr #(
  parameter int adr_width = 24,
  parameter int to_length = 8,
  parameter int to_limit  = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          m0_dat_i,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [2:0]           m0_cti_i,
  input  logic [1:0]           m0_bte_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [31:0]          m1_dat_i,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [2:0]           m1_cti_i,
  input  logic [1:0]           m1_bte_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic [31:0]          m_dat_o,
  output logic [31:0]          s_dat_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [3:0]           s_sel_o,
  output logic [2:0]           s_cti_o,
  output logic [1:0]           s_bte_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [to_length-1:0] wd_limit = to_length'(to_limit);

  state_t               state, state_nxt;
  logic                 prio;
  logic                 lock0, lock1;
  logic [to_length-1:0] wd_cnt;
  logic                 req0, req1, stalled, timeout;

  // A master that was timed out stays locked out until it drops cyc.
  assign req0    = m0_cyc_i & ~lock0;
  assign req1    = m1_cyc_i & ~lock1;
  assign stalled = (state != IDLE) & s_stb_o & ~s_ack_i;
  assign timeout = stalled & (wd_cnt == wd_limit);

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset,
  // so every register updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT0 && state != GNT0)
        prio <= 1'b1;
      else if (state_nxt == GNT1 && state != GNT1)
        prio <= 1'b0;
    end
  end

  // NOTE: every signal gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || !prio)) state_nxt = GNT0;
        else if (req1)                state_nxt = GNT1;
      end
      GNT0: begin
        if (timeout)        state_nxt = IDLE;
        else if (!m0_cyc_i) state_nxt = req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        if (timeout)        state_nxt = IDLE;
        else if (!m1_cyc_i) state_nxt = req0 ? GNT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (state)
      GNT0: begin
        s_dat_o = m0_dat_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & m0_cyc_i;
      end
      GNT1: begin
        s_dat_o = m1_dat_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & m1_cyc_i;
      end
      default: ;
    endcase
  end

  // Termination goes straight through; timeout already excludes an ack in the same cycle.
  assign m0_ack_o = s_ack_i & (state == GNT0) & m0_cyc_i;
  assign m1_ack_o = s_ack_i & (state == GNT1) & m1_cyc_i;
  assign m0_err_o = timeout & (state == GNT0);
  assign m1_err_o = timeout & (state == GNT1);
  assign m_dat_o  = s_dat_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      lock0  <= 1'b0;
      lock1  <= 1'b0;
    end else begin
      if (!stalled || timeout)    wd_cnt <= '0;
      else if (wd_cnt != wd_limit) wd_cnt <= wd_cnt + to_length'(1);
      if (m0_err_o)       lock0 <= 1'b1;
      else if (!m0_cyc_i) lock0 <= 1'b0;
      if (m1_err_o)       lock1 <= 1'b1;
      else if (!m1_cyc_i) lock1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arb_2m_sdr.sv
// Scoreboard bench for wb_arb_2m_sdr: stimulus pushes expected grants and terminations,
// monitors pop and compare whenever the DUT raises s_cyc_o or an ack/err.
module tb_wb_arb_2m_sdr;

  typedef struct packed {
    logic        m;
    logic        err;
    logic [31:0] dat;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_dat_i, m1_dat_i, s_dat_i;
  logic [23:0] m0_adr_i, m1_adr_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i, s_ack_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m_dat_o, s_dat_o;
  logic [23:0] s_adr_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_we_o, s_cyc_o, s_stb_o;

  int          n_checks = 0;
  int          n_errors = 0;
  resp_t       resp_q[$];
  logic [23:0] grant_q[$];

  always #5 clk = ~clk;

  wb_arb_2m_sdr dut (
    .clk(clk), .rst_n(rst_n),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
    .m0_bte_i(m0_bte_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
    .m1_bte_i(m1_bte_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m_dat_o(m_dat_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic m0_req(input logic [23:0] adr, input logic we, input logic [31:0] dat,
                        input logic [2:0] cti, input logic [1:0] bte);
    m0_adr_i = adr; m0_we_i = we; m0_dat_i = dat; m0_cti_i = cti; m0_bte_i = bte;
    m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
  endtask

  task automatic m1_req(input logic [23:0] adr, input logic we, input logic [31:0] dat,
                        input logic [2:0] cti, input logic [1:0] bte);
    m1_adr_i = adr; m1_we_i = we; m1_dat_i = dat; m1_cti_i = cti; m1_bte_i = bte;
    m1_sel_i = 4'hF; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
  endtask

  task automatic m0_drop();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
  endtask

  task automatic m1_drop();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
  endtask

  task automatic push_resp(input logic m, input logic err, input logic [31:0] dat);
    resp_t e;
    e.m = m; e.err = err; e.dat = dat;
    resp_q.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Termination monitor: every ack/err must match the next expected response.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o) begin
        check("resp_onehot", 32'(m0_ack_o) + 32'(m1_ack_o) + 32'(m0_err_o) + 32'(m1_err_o), 1);
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = resp_q.pop_front();
          check("resp_master", m1_ack_o | m1_err_o, e.m);
          check("resp_err", m0_err_o | m1_err_o, e.err);
          if (!e.err) check("resp_dat", m_dat_o, e.dat);
        end
      end
    end
  end

  // Grant monitor: each rising s_cyc_o must present the expected master's address.
  initial begin
    logic prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (s_cyc_o && !prev_cyc) begin
        if (grant_q.size() == 0) check("unexpected_grant", 1, 0);
        else check("grant_adr", s_adr_o, grant_q.pop_front());
      end
      prev_cyc = s_cyc_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, got t=%0t, expected < 100000", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    {m0_dat_i, m0_adr_i, m0_sel_i, m0_cti_i, m0_bte_i, m0_we_i, m0_cyc_i, m0_stb_i} = '0;
    {m1_dat_i, m1_adr_i, m1_sel_i, m1_cti_i, m1_bte_i, m1_we_i, m1_cyc_i, m1_stb_i} = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;

    // Reset state
    mid();
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_stb", s_stb_o, 0);
    check("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single write from m0, grant one cycle after cyc
    m0_req(24'h000010, 1'b1, 32'hA5A5_0001, 3'b000, 2'b00);
    grant_q.push_back(24'h000010);
    mid();
    check("t1_no_grant_yet", s_cyc_o, 0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_0000;
    push_resp(1'b0, 1'b0, 32'h0000_0000);
    mid();
    check("t1_s_cyc", s_cyc_o, 1);
    check("t1_s_dat", s_dat_o, 32'hA5A5_0001);
    check("t1_s_we", s_we_o, 1);
    check("t1_m0_ack", m0_ack_o, 1);
    check("t1_m1_ack", m1_ack_o, 0);
    tick();
    s_ack_i = 1'b0;
    m0_drop();
    mid();
    check("t1_release", s_cyc_o, 0);
    tick();

    // 2: two simultaneous ties from reset priority: m0 first, then m1
    apply_reset();
    m0_req(24'h000100, 1'b0, 32'h0, 3'b000, 2'b00);
    m1_req(24'h000200, 1'b0, 32'h0, 3'b000, 2'b00);
    grant_q.push_back(24'h000100);
    mid();
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1111_0000;
    push_resp(1'b0, 1'b0, 32'h1111_0000);
    mid();
    check("t2_m1_waits", m1_ack_o, 0);
    tick();
    s_ack_i = 1'b0;
    m0_drop();
    m1_drop();
    mid();
    tick();
    m0_req(24'h000100, 1'b0, 32'h0, 3'b000, 2'b00);
    m1_req(24'h000200, 1'b0, 32'h0, 3'b000, 2'b00);
    grant_q.push_back(24'h000200);
    mid();
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h2222_0000;
    push_resp(1'b1, 1'b0, 32'h2222_0000);
    mid();
    check("t2_m0_waits", m0_ack_o, 0);
    tick();
    s_ack_i = 1'b0;
    m0_drop();
    m1_drop();
    mid();
    tick();

    // 3: m1 requests during an m0 4-beat wrap read
    m0_req(24'h000402, 1'b0, 32'h0, 3'b010, 2'b01);
    grant_q.push_back(24'h000402);
    mid();
    tick();
    m1_req(24'h000800, 1'b0, 32'h0, 3'b000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      m0_adr_i = 24'h000400 + 24'((i + 2) % 4);
      m0_cti_i = (i == 3) ? 3'b111 : 3'b010;
      s_ack_i  = 1'b1;
      s_dat_i  = 32'hD000_0000 + 32'(i);
      push_resp(1'b0, 1'b0, 32'hD000_0000 + 32'(i));
      mid();
      check("t3_s_bte", s_bte_o, 2'b01);
      check("t3_m1_no_ack", m1_ack_o, 0);
      tick();
    end
    s_ack_i = 1'b0;
    m0_drop();
    grant_q.push_back(24'h000800);
    mid();
    check("t3_dead_cycle", s_cyc_o, 0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h3333_0000;
    push_resp(1'b1, 1'b0, 32'h3333_0000);
    mid();
    check("t3_m1_granted", s_adr_o, 24'h000800);
    tick();
    s_ack_i = 1'b0;
    m1_drop();
    mid();
    tick();

    // 4: watchdog fires after 200 stalled cycles, then lockout until cyc drops
    m0_req(24'h000020, 1'b1, 32'hC0DE_0004, 3'b000, 2'b00);
    grant_q.push_back(24'h000020);
    mid();
    tick();
    push_resp(1'b0, 1'b1, 32'h0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      mid();
      if (m0_err_o) break;
      n++;
      tick();
    end
    check("t4_stall_cycles", n, 200);
    tick();
    mid();
    check("t4_cyc_dropped", s_cyc_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      mid();
      check("t4_lockout", s_cyc_o, 0);
    end
    tick();
    m0_drop();
    mid();
    tick();
    m0_req(24'h000020, 1'b1, 32'hC0DE_0004, 3'b000, 2'b00);
    grant_q.push_back(24'h000020);
    mid();
    check("t4_regrant_wait", s_cyc_o, 0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h4444_0000;
    push_resp(1'b0, 1'b0, 32'h4444_0000);
    mid();
    check("t4_regrant", s_cyc_o, 1);
    tick();
    s_ack_i = 1'b0;
    m0_drop();
    mid();
    tick();

    // 5: ack arriving in the timeout cycle wins over err
    m0_req(24'h000030, 1'b0, 32'h0, 3'b000, 2'b00);
    grant_q.push_back(24'h000030);
    mid();
    tick();
    for (int i = 0; i < 200; i++) begin
      mid();
      tick();
    end
    s_ack_i = 1'b1;
    s_dat_i = 32'h5A5A_0005;
    push_resp(1'b0, 1'b0, 32'h5A5A_0005);
    mid();
    check("t5_no_err", m0_err_o, 0);
    check("t5_ack", m0_ack_o, 1);
    tick();
    s_ack_i = 1'b0;
    m0_drop();
    mid();
    tick();

    // 6: reset in the middle of an m1 burst, then a tie goes to m0
    m1_req(24'h000900, 1'b0, 32'h0, 3'b010, 2'b00);
    grant_q.push_back(24'h000900);
    mid();
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'hE000_0000;
    push_resp(1'b1, 1'b0, 32'hE000_0000);
    mid();
    tick();
    s_ack_i = 1'b0;
    m1_adr_i = 24'h000901;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_s_cyc", s_cyc_o, 0);
    check("t6_rst_s_stb", s_stb_o, 0);
    check("t6_rst_s_adr", s_adr_o, 24'h0);
    s_ack_i = 1'b1;
    #1;
    check("t6_rst_m1_ack", m1_ack_o, 0);
    mid();
    tick();
    s_ack_i = 1'b0;
    m1_drop();
    tick();
    rst_n = 1'b1;
    m0_req(24'h000A00, 1'b0, 32'h0, 3'b000, 2'b00);
    m1_req(24'h000B00, 1'b0, 32'h0, 3'b000, 2'b00);
    grant_q.push_back(24'h000A00);
    mid();
    check("t6_idle_after_rst", s_cyc_o, 0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h6666_0000;
    push_resp(1'b0, 1'b0, 32'h6666_0000);
    mid();
    check("t6_tie_to_m0", s_adr_o, 24'h000A00);
    tick();
    s_ack_i = 1'b0;
    m0_drop();
    m1_drop();
    mid();
    tick();
    tick();

    check("resp_q_drained", resp_q.size(), 0);
    check("grant_q_drained", grant_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
